// File: rtl/axi_stream_sync_fifo.sv
// Single-clock AXI4-Stream FIFO, registered-only handshakes.
// Optional packet mode: define AXIS_FIFO_PACKET_MODE_EN.
module axi_stream_sync_fifo #(
  parameter int byte_width = 4,
  parameter int id_width   = 1,
  parameter int dest_width = 1,
  parameter int user_width = 1,
  parameter int depth_log2 = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic [8*byte_width-1:0] s_tdata,
  input  logic [byte_width-1:0]   s_tstrb,
  input  logic [byte_width-1:0]   s_tkeep,
  input  logic                    s_tlast,
  input  logic [id_width-1:0]     s_tid,
  input  logic [dest_width-1:0]   s_tdest,
  input  logic [user_width-1:0]   s_tuser,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [8*byte_width-1:0] m_tdata,
  output logic [byte_width-1:0]   m_tstrb,
  output logic [byte_width-1:0]   m_tkeep,
  output logic                    m_tlast,
  output logic [id_width-1:0]     m_tid,
  output logic [dest_width-1:0]   m_tdest,
  output logic [user_width-1:0]   m_tuser,
  output logic [depth_log2:0]     level
);

  localparam int DW    = 8 * byte_width;
  localparam int EW    = DW + 2 * byte_width + 1
                       + id_width + dest_width + user_width;
  localparam int DEPTH = 1 << depth_log2;
  localparam logic [depth_log2:0] FULL_CNT =
    {1'b1, {depth_log2{1'b0}}};
  localparam logic [depth_log2:0] CNT_ONE =
    (depth_log2 + 1)'(1);
  localparam logic [depth_log2-1:0] PTR_ONE =
    depth_log2'(1);

  logic [EW-1:0]         mem_q [DEPTH];
  logic [depth_log2-1:0] wptr_q, wptr_d;
  logic [depth_log2-1:0] rptr_q, rptr_d;
  logic [depth_log2:0]   cnt_q, cnt_d;
  logic                  en_q;
  logic                  full, empty;
  logic                  push, pop;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);

  // en_q keeps s_tready low until the first edge after reset
  assign s_tready = en_q & ~full;

`ifdef AXIS_FIFO_PACKET_MODE_EN
  logic [depth_log2:0] pkt_q, pkt_d;
  // full term releases packets longer than the FIFO
  assign m_tvalid = ~empty & ((pkt_q != '0) | full);
`else
  assign m_tvalid = ~empty;
`endif

  assign push  = s_tvalid & s_tready;
  assign pop   = m_tvalid & m_tready;
  assign level = cnt_q;

  assign {m_tdata, m_tstrb, m_tkeep, m_tlast,
          m_tid, m_tdest, m_tuser} = mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = wptr_q + PTR_ONE;
    if (pop)  rptr_d = rptr_q + PTR_ONE;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      en_q   <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      en_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wptr_q] <= {s_tdata, s_tstrb, s_tkeep, s_tlast,
                        s_tid, s_tdest, s_tuser};
  end

`ifdef AXIS_FIFO_PACKET_MODE_EN
  logic pkt_in, pkt_out;

  assign pkt_in  = push & s_tlast;
  assign pkt_out = pop & m_tlast;

  always_comb begin
    pkt_d = pkt_q;
    unique case ({pkt_in, pkt_out})
      2'b10:   pkt_d = pkt_q + CNT_ONE;
      2'b01:   pkt_d = pkt_q - CNT_ONE;
      default: pkt_d = pkt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pkt_q <= '0;
    else       pkt_q <= pkt_d;
  end
`endif

endmodule

// File: tb/tb_axi_stream_sync_fifo.sv
// Bench for axi_stream_sync_fifo: table vectors, corner
// sequences and random traffic against a queue model.
module tb_axi_stream_sync_fifo;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_tvalid, s_tready;
  logic [31:0] s_tdata;
  logic [3:0]  s_tstrb, s_tkeep;
  logic        s_tlast;
  logic [1:0]  s_tid, s_tdest, s_tuser;
  logic        m_tvalid, m_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb, m_tkeep;
  logic        m_tlast;
  logic [1:0]  m_tid, m_tdest, m_tuser;
  logic [2:0]  level;

  axi_stream_sync_fifo #(
    .byte_width(4), .id_width(2), .dest_width(2),
    .user_width(2), .depth_log2(2)
  ) dut (
    .clk(clk), .reset(reset),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tdata(s_tdata), .s_tstrb(s_tstrb),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tdata(m_tdata), .m_tstrb(m_tstrb),
    .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser),
    .level(level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  s;
    logic [3:0]  k;
    logic        l;
    logic [1:0]  id;
    logic [1:0]  de;
    logic [1:0]  u;
  } beat_t;

  typedef struct {
    bit          sv;
    bit          mr;
    logic [31:0] d;
    int          lvl;
    bit          rdy;
    bit          val;
    logic [31:0] ed;
  } vec_t;

  beat_t       mq[$];
  logic [32:0] outq[$];
  bit          rdy_en = 0;
  int          nchk = 0;
  int          nfail = 0;

  function automatic void chk(string n, logic [63:0] a,
                              logic [63:0] e);
    nchk++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               n, a, e, $time);
    end
  endfunction

  function automatic bit exp_rdy();
    return rdy_en && (mq.size() < DEPTH);
  endfunction

  function automatic bit exp_val();
    bit hl;
    hl = 0;
    if (mq.size() == 0) return 0;
`ifdef AXIS_FIFO_PACKET_MODE_EN
    foreach (mq[i]) if (mq[i].l) hl = 1;
    return hl || (mq.size() == DEPTH);
`else
    hl = 1;
    return hl;
`endif
  endfunction

  function automatic void check_model();
    beat_t a;
    chk("s_tready", 64'(s_tready), 64'(exp_rdy()));
    chk("m_tvalid", 64'(m_tvalid), 64'(exp_val()));
    chk("level", 64'(level), 64'(mq.size()));
    if (exp_val() && m_tvalid) begin
      a = {m_tdata, m_tstrb, m_tkeep, m_tlast,
           m_tid, m_tdest, m_tuser};
      chk("payload", 64'(a), 64'(mq[0]));
    end
  endfunction

  task automatic cyc();
    bit    push, pop;
    beat_t b;
    #2;
    push = s_tvalid && exp_rdy();
    pop  = exp_val() && m_tready;
    b = {s_tdata, s_tstrb, s_tkeep, s_tlast,
         s_tid, s_tdest, s_tuser};
    if (m_tvalid && m_tready)
      outq.push_back({m_tlast, m_tdata});
    @(posedge clk);
    #1;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(b);
    if (!reset) rdy_en = 1;
    check_model();
  endtask

  task automatic set_beat(logic [31:0] d, logic l);
    s_tdata = d;
    s_tstrb = 4'(d);
    s_tkeep = 4'(d >> 4);
    s_tlast = l;
    s_tid   = 2'(d >> 8);
    s_tdest = 2'(d >> 10);
    s_tuser = 2'(d >> 12);
  endtask

  task automatic drain();
    int n;
    n = 0;
    s_tvalid = 0;
    m_tready = 1;
    while (mq.size() != 0 && n < 30) begin
      cyc();
      n++;
    end
    chk("drain_done", 64'(mq.size()), 64'd0);
  endtask

  vec_t tv[11];

  initial begin
    int  j, n;
    bit  wp, saw_full;

    tv[0]  = '{1, 0, 32'hA0, 1, 1, 1, 32'hA0};
    tv[1]  = '{1, 0, 32'hA1, 2, 1, 1, 32'hA0};
    tv[2]  = '{1, 0, 32'hA2, 3, 1, 1, 32'hA0};
    tv[3]  = '{1, 0, 32'hA3, 4, 0, 1, 32'hA0};
    for (int i = 4; i < 9; i++)
      tv[i] = '{1, 0, 32'hA4, 4, 0, 1, 32'hA0};
    tv[9]  = '{1, 1, 32'hA4, 3, 1, 1, 32'hA1};
    tv[10] = '{1, 0, 32'hA4, 4, 0, 1, 32'hA1};

    reset    = 1;
    s_tvalid = 1;
    m_tready = 0;
    set_beat(32'h55, 1);
    #1;
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    cyc();
    cyc();
    reset    = 0;
    s_tvalid = 0;
    cyc();
    chk("ready_after_rst", 64'(s_tready), 64'd1);

    // fill, stall, then pop while full
    foreach (tv[i]) begin
      s_tvalid = tv[i].sv;
      m_tready = tv[i].mr;
      set_beat(tv[i].d, 1);
      cyc();
      chk("tv_level", 64'(level), 64'(tv[i].lvl));
      chk("tv_s_tready", 64'(s_tready), 64'(tv[i].rdy));
      chk("tv_m_tvalid", 64'(m_tvalid), 64'(tv[i].val));
      chk("tv_m_tdata", 64'(m_tdata), 64'(tv[i].ed));
    end
    drain();

    // continuous 20-beat stream
    outq.delete();
    m_tready = 1;
    s_tvalid = 1;
    for (int i = 0; i < 20; i++) begin
      set_beat(32'(i), (i == 7) || (i == 19));
      cyc();
`ifndef AXIS_FIFO_PACKET_MODE_EN
      chk("stream_level", 64'(level), 64'd1);
      chk("stream_valid", 64'(m_tvalid), 64'd1);
`endif
    end
    drain();
    chk("stream_count", 64'(outq.size()), 64'd20);
    for (int i = 0; i < 20 && i < outq.size(); i++)
      chk("stream_beat", 64'(outq[i]),
          {31'd0, (i == 7) || (i == 19), 32'(i)});

    // reset while holding a stalled transfer
    m_tready = 0;
    s_tvalid = 1;
    for (int i = 0; i < 3; i++) begin
      set_beat(32'h100 + 32'(i), 1);
      cyc();
    end
    chk("pre_rst_level", 64'(level), 64'd3);
    #2;
    reset = 1;
    #1;
    mq.delete();
    rdy_en = 0;
    chk("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("midrst_level", 64'(level), 64'd0);
    chk("midrst_s_tready", 64'(s_tready), 64'd0);
    s_tvalid = 0;
    cyc();
    reset    = 0;
    m_tready = 1;
    for (int i = 0; i < 4; i++) cyc();

    // packet gating: three beats without tlast
    m_tready = 0;
    s_tvalid = 1;
    for (int i = 0; i < 3; i++) begin
      set_beat(32'h200 + 32'(i), 0);
      cyc();
    end
`ifdef AXIS_FIFO_PACKET_MODE_EN
    chk("pkt_hold", 64'(m_tvalid), 64'd0);
`endif
    set_beat(32'h203, 1);
    cyc();
    s_tvalid = 0;
    cyc();
    chk("pkt_release", 64'(m_tvalid), 64'd1);
    drain();

    // six-beat packet through a four-deep FIFO
    outq.delete();
    m_tready = 1;
    s_tvalid = 1;
    j = 0;
    n = 0;
    saw_full = 0;
    while ((j < 6 || mq.size() != 0) && n < 60) begin
      set_beat(32'h300 + 32'(j), j == 5);
      wp = s_tvalid && exp_rdy();
      cyc();
      if (level == 3'd4 && m_tvalid) saw_full = 1;
      if (wp) j++;
      if (j == 6) s_tvalid = 0;
      n++;
    end
    chk("long_pkt_done", 64'(n < 60), 64'd1);
    chk("long_pkt_count", 64'(outq.size()), 64'd6);
    for (int i = 0; i < 6 && i < outq.size(); i++)
      chk("long_pkt_beat", 64'(outq[i]),
          {31'd0, i == 5, 32'h300 + 32'(i)});
`ifdef AXIS_FIFO_PACKET_MODE_EN
    chk("long_pkt_full_valid", 64'(saw_full), 64'd1);
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      s_tvalid = 1'($urandom);
      m_tready = ($urandom_range(3) != 0);
      set_beat($urandom, $urandom_range(3) == 0);
      cyc();
    end
    set_beat(32'h0, 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/axi_stream_sync_fifo.md
Name: axi_stream_sync_fifo

Overview:
- Single-clock AXI4-Stream FIFO that buffers beats between an upstream master and a downstream slave.
- The m_* port is the interface checked by the team's AXI-Stream slave property set, so every master-side rule (TVALID hold, payload stability, reset quiescence, TSTRB⊆TKEEP passthrough) must hold on it.
- The s_* port accepts beats from an upstream producer.

Parameters:
byte_width, 4, TDATA bytes; must be ≥1.
id_width, 1, TID width; must be ≥1 (tie off if unused).
dest_width, 1, TDEST width; must be ≥1.
user_width, 1, TUSER width; must be ≥1.
depth_log2, 4, FIFO holds 2**depth_log2 beats; must be ≥1.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
s_tvalid  in  1  upstream beat valid.
s_tready  out  1  FIFO can accept a beat.
s_tdata  in  8*byte_width  payload.
s_tstrb  in  byte_width  byte qualifier.
s_tkeep  in  byte_width  byte keep.
s_tlast  in  1  packet end.
s_tid  in  id_width  stream id.
s_tdest  in  dest_width  routing.
s_tuser  in  user_width  sideband.
m_tvalid  out  1  downstream beat valid.
m_tready  in  1  downstream ready.
m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser  out  widths as s_*  stored beat.
level  out  depth_log2+1  beats currently stored.

Behaviour:
- Storage: 2**depth_log2 entries, each holding all payload fields. Write pointer, read pointer and count are registered.
- push = s_tvalid & s_tready. pop = m_tvalid & m_tready.
- s_tready = (count != 2**depth_log2), decoded from registered state only. No combinational path from m_tready or s_tvalid to s_tready.
- m_tvalid = (count != 0), from registered state only. No combinational path from s_* to m_*.
- Payload fields on m_* are read combinationally from the entry at the read pointer, so they are stable while m_tvalid & !m_tready.
- Latency: a beat pushed at edge N presents m_tvalid=1 in the cycle after edge N. No fall-through in the same cycle.
- count update: push only → +1; pop only → −1; both → unchanged. Pointers wrap modulo 2**depth_log2.
- Full (count = max): s_tready=0. A simultaneous pop does not enable a same-cycle push; s_tready rises the cycle after the pop.
- Empty: m_tvalid=0, so a pop is impossible and a push proceeds normally.
- level = count.
- Order, tlast, tstrb and tkeep are preserved bit-exact. The block does not check TSTRB⊆TKEEP; it passes the fields through unmodified.
- Reset values (asynchronous, immediate on reset assertion): pointers=0, count=0, level=0, m_tvalid=0, s_tready=0.
- s_tready goes to 1 at the first rising edge after reset deasserts. m_tvalid cannot rise before the cycle after the first post-reset push.
- Reset mid-operation: all stored beats are discarded with no drain. m_tvalid drops immediately even if a transfer was stalled. This is the only permitted TVALID drop without a handshake.
- Storage array contents are not reset; outputs read from it are don't-care while m_tvalid=0.

Optional Feature:
- Macro: AXIS_FIFO_PACKET_MODE_EN.
- When defined, the block keeps a registered packet counter: +1 when a beat with s_tlast=1 is pushed, −1 when a beat with m_tlast=1 is popped, no change when both happen.
- When defined, m_tvalid = (count != 0) & ((pkt_count != 0) | full). The full term prevents deadlock on packets longer than the FIFO depth.
- Once m_tvalid is asserted it must remain asserted until the pop.
- When undefined, m_tvalid = (count != 0) and there is no packet counter.

Test Plan:
- reset held, s_tvalid=1 → s_tready=0, m_tvalid=0, level=0. Release reset → s_tready=1 at the next edge.
- depth_log2=2, push 4 beats with m_tready=0 → level=4, s_tready=0. m_tvalid stays 1 and m_tdata holds beat0 unchanged across 5 stalled cycles.
- Full FIFO, m_tready=1, s_tvalid=1 → pop in cycle k, s_tready=1 in cycle k+1, level reads 3 then 4.
- Continuous stream of 20 beats (tdata = index, tlast on 7 and 19) with m_tready=1 → output order and tlast identical; steady-state level=1; 1 beat/cycle throughput after 1-cycle latency.
- Assert reset while level=3 and m_tready=0 → m_tvalid=0 immediately; after release level=0 and no stale beats appear.
- With AXIS_FIFO_PACKET_MODE_EN: push 3 beats with no tlast → m_tvalid=0. Push a 4th beat with tlast=1 → m_tvalid=1 next cycle.
- With AXIS_FIFO_PACKET_MODE_EN, depth 4: 6-beat packet → m_tvalid=1 when full; packet drains fully.
